// File: rtl/dct_mac_if.sv
// Product-in / coefficient-out handshake bundle for the DCT accumulator stage.
interface dct_mac_if #(
  parameter int PROD_W = 24,
  parameter int OUT_W  = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_first;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_coef;
  logic              out_sat;

  modport master (
    output in_valid, in_prod, in_first, out_ready,
    input  in_ready, out_valid, out_coef, out_sat
  );

  modport slave (
    input  in_valid, in_prod, in_first, out_ready,
    output in_ready, out_valid, out_coef, out_sat
  );
endinterface

// File: rtl/dct_mac_accum.sv
// DCT MAC accumulator: sums TERMS products per coefficient, rounds/scales/saturates,
// and hands finished coefficients out through a 2-entry valid/ready queue.
module dct_mac_accum #(
  parameter int PROD_W    = 24,
  parameter int TERMS     = 8,
  parameter int FRAC_BITS = 11,
  parameter int OUT_W     = 12
) (
  input  logic     clk,
  input  logic     rst,
  dct_mac_if.slave bus,
  output logic     err_sync
);
  localparam int CNT_W = $clog2(TERMS);
  localparam int ACC_W = PROD_W + CNT_W;
  localparam int RW    = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(TERMS - 1);
  localparam logic signed [RW-1:0] RND_HALF = RW'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [RW-1:0] COEF_MAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] COEF_MIN = RW'(-(64'sd1 <<< (OUT_W - 1)));

  // Round half-up on a one-bit-widened sum, then clip; returns {sat, coef}.
  function automatic logic [OUT_W:0] round_clip(input logic signed [ACC_W-1:0] sum);
    logic signed [RW-1:0] wide;
    logic signed [RW-1:0] r;
    wide = RW'({sum[ACC_W-1], sum}) + RND_HALF;
    r    = wide >>> FRAC_BITS;
    if (r > COEF_MAX) begin
      return {1'b1, COEF_MAX[OUT_W-1:0]};
    end else if (r < COEF_MIN) begin
      return {1'b1, COEF_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, r[OUT_W-1:0]};
    end
  endfunction

  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic signed [ACC_W-1:0] acc_r, acc_nxt_s, prod_ext_s, sum_s;
  logic                    err_r, err_nxt_s;
  logic [1:0]              q_count_r, q_count_nxt_s;
  logic [OUT_W-1:0]        head_coef_r, head_coef_nxt_s, tail_coef_r, tail_coef_nxt_s;
  logic                    head_sat_r, head_sat_nxt_s, tail_sat_r, tail_sat_nxt_s;
  logic                    in_ready_r, out_valid_r;
  logic                    accept_s, pop_s, push_s, push_sat_s;
  logic [OUT_W-1:0]        push_coef_s;

  assign accept_s   = bus.in_valid && in_ready_r;
  assign pop_s      = out_valid_r && bus.out_ready;
  assign prod_ext_s = {{CNT_W{bus.in_prod[PROD_W-1]}}, bus.in_prod};
  assign sum_s      = acc_r + prod_ext_s;

  // Term counting, accumulation, resync on a misplaced in_first, group-end push.
  always_comb begin
    acc_nxt_s = acc_r;
    cnt_nxt_s = cnt_r;
    err_nxt_s = err_r;
    push_s    = 1'b0;
    {push_sat_s, push_coef_s} = round_clip(sum_s);
    if (accept_s) begin
      if (bus.in_first || (cnt_r == CNT_ZERO)) begin
        acc_nxt_s = prod_ext_s;
        cnt_nxt_s = CNT_ONE;
        err_nxt_s = err_r || (cnt_r != CNT_ZERO);
      end else if (cnt_r == LAST_TERM) begin
        acc_nxt_s = sum_s;
        cnt_nxt_s = CNT_ZERO;
        push_s    = 1'b1;
      end else begin
        acc_nxt_s = sum_s;
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Two-slot FIFO: head feeds the outputs, tail only fills when head is occupied.
  always_comb begin
    q_count_nxt_s   = q_count_r;
    head_coef_nxt_s = head_coef_r;
    head_sat_nxt_s  = head_sat_r;
    tail_coef_nxt_s = tail_coef_r;
    tail_sat_nxt_s  = tail_sat_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (q_count_r == 2'd0) begin
          head_coef_nxt_s = push_coef_s;
          head_sat_nxt_s  = push_sat_s;
          q_count_nxt_s   = 2'd1;
        end else if (q_count_r == 2'd1) begin
          tail_coef_nxt_s = push_coef_s;
          tail_sat_nxt_s  = push_sat_s;
          q_count_nxt_s   = 2'd2;
        end else begin
          q_count_nxt_s = q_count_r;
        end
      end
      2'b01: begin
        head_coef_nxt_s = tail_coef_r;
        head_sat_nxt_s  = tail_sat_r;
        q_count_nxt_s   = q_count_r - 2'd1;
      end
      2'b11: begin
        if (q_count_r == 2'd2) begin
          head_coef_nxt_s = tail_coef_r;
          head_sat_nxt_s  = tail_sat_r;
          tail_coef_nxt_s = push_coef_s;
          tail_sat_nxt_s  = push_sat_s;
        end else begin
          head_coef_nxt_s = push_coef_s;
          head_sat_nxt_s  = push_sat_s;
        end
      end
      default: begin
        q_count_nxt_s = q_count_r;
      end
    endcase
  end

  // State registers; handshake flags are registered from the next queue count.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      err_r       <= 1'b0;
      q_count_r   <= 2'd0;
      head_coef_r <= {OUT_W{1'b0}};
      head_sat_r  <= 1'b0;
      tail_coef_r <= {OUT_W{1'b0}};
      tail_sat_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      err_r       <= err_nxt_s;
      q_count_r   <= q_count_nxt_s;
      head_coef_r <= head_coef_nxt_s;
      head_sat_r  <= head_sat_nxt_s;
      tail_coef_r <= tail_coef_nxt_s;
      tail_sat_r  <= tail_sat_nxt_s;
      in_ready_r  <= (q_count_nxt_s < 2'd2);
      out_valid_r <= (q_count_nxt_s != 2'd0);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_coef  = head_coef_r;
  assign bus.out_sat   = head_sat_r;
  assign err_sync      = err_r;
endmodule
